// File: rtl/sha1_accel_pkg.sv
// sha1_accel_pkg: shared states, SHA-1 constants and the rotate helper
package sha1_accel_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ROUND = 2'b01, DONE = 2'b10} state_e;
  localparam int ROUNDS = 80;
  localparam logic [4:0][31:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                     32'hEFCDAB89, 32'h67452301};
  localparam logic [3:0][31:0] K = {32'hCA62C1D6, 32'h8F1BBCDC, 32'h6ED9EBA1, 32'h5A827999};
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/sha1_msg_schedule.sv
// sha1_msg_schedule: 16-word circular buffer producing W_t, expanding in place from t=16
module sha1_msg_schedule
  import sha1_accel_pkg::*;
(
  input  logic              clk,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [6:0]        t_i,
  input  logic [15:0][31:0] data_i,
  output logic [31:0]       w_o
);
  logic [15:0][31:0] win_q;
  logic [3:0]        p;
  assign p = t_i[3:0];
  // slot p holds W[t-16]; it is overwritten with W[t] once consumed
  assign w_o = (t_i < 7'd16) ? win_q[p]
             : rotl(win_q[p - 4'd3] ^ win_q[p - 4'd8] ^ win_q[p - 4'd14] ^ win_q[p], 1);
  always_ff @(posedge clk)
    if (load_i) win_q <= data_i;
    else if (adv_i) win_q[p] <= w_o;
endmodule

// File: rtl/sha1_chain_accel.sv
// sha1_chain_accel: one-round-per-clock SHA-1 with multi-block chaining.
// Define SHA1_ASYNC_START_EN to enable the synchronised single-block start input.
module sha1_chain_accel
  import sha1_accel_pkg::*;
#(
  parameter int MAX_BLOCKS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_enable,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_first,
  input  logic                               in_last,
  input  logic [15:0][31:0]                  in_data,
  input  logic                               start,
  input  logic                               err_clr,
  output logic [4:0][31:0]                   digest,
  output logic                               digest_valid,
  output logic                               busy,
  output logic [1:0]                         q_state,
  output logic [$clog2(MAX_BLOCKS+1)-1:0]    blk_cnt,
  output logic [1:0]                         err
);
  localparam int CW = $clog2(MAX_BLOCKS + 1);
  state_e            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [4:0][31:0]  v_q, v_d, h_q, h_d, digest_q, digest_d;
  logic              dv_q, dv_d, last_q, last_d, open_q, open_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        err_q, err_d, grp;
  logic              start_rise, acc, eff_first, eff_last;
  logic [31:0]       w_t, f, tmp;

`ifdef SHA1_ASYNC_START_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], start};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign start_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
`else
  logic unused_start;
  localparam int unused_sync = SYNC_STAGES;
  assign unused_start = start;
  assign start_rise   = 1'b0;
`endif

  assign in_ready  = reset_n & cfg_enable & (state_q == IDLE);
  // a start edge coinciding with in_valid is simply absorbed by the handshake
  assign acc       = in_ready & (in_valid | start_rise);
  assign eff_first = ~in_valid | in_first | ~open_q;
  assign eff_last  = ~in_valid | in_last;
  assign grp = t_q < 7'd20 ? 2'd0 : t_q < 7'd40 ? 2'd1 : t_q < 7'd60 ? 2'd2 : 2'd3;
  assign f = grp == 2'd0 ? (v_q[1] & v_q[2]) | (~v_q[1] & v_q[3])
           : grp == 2'd2 ? (v_q[1] & v_q[2]) | (v_q[1] & v_q[3]) | (v_q[2] & v_q[3])
           : v_q[1] ^ v_q[2] ^ v_q[3];
  assign tmp = rotl(v_q[0], 5) + f + v_q[4] + K[grp] + w_t;

  sha1_msg_schedule u_sched (
    .clk    (clk),
    .load_i (acc),
    .adv_i  (state_q == ROUND),
    .t_i    (t_q),
    .data_i (in_data),
    .w_o    (w_t)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    v_d      = v_q;
    h_d      = h_q;
    digest_d = digest_q;
    dv_d     = 1'b0;
    last_d   = last_q;
    open_d   = open_q;
    cnt_d    = cnt_q;
    err_d    = err_clr ? 2'b00 : err_q;
    case (state_q)
      IDLE: if (acc) begin
        v_d      = eff_first ? IV : h_q;
        h_d      = v_d;
        t_d      = '0;
        last_d   = eff_last;
        open_d   = 1'b1;
        cnt_d    = eff_first ? '0 : cnt_q;
        err_d[0] = err_d[0] | (in_valid & ~in_first & ~open_q);
        err_d[1] = err_d[1] | (~eff_first & (cnt_q == CW'(MAX_BLOCKS)));
        state_d  = ROUND;
      end
      ROUND: begin
        v_d     = {v_q[3], v_q[2], rotl(v_q[1], 30), v_q[0], tmp};
        t_d     = t_q + 7'd1;
        state_d = (t_q == 7'(ROUNDS - 1)) ? DONE : ROUND;
      end
      DONE: begin
        for (int i = 0; i < 5; i++) h_d[i] = h_q[i] + v_q[i];
        cnt_d    = (cnt_q == CW'(MAX_BLOCKS)) ? cnt_q : cnt_q + CW'(1);
        digest_d = last_q ? h_d : digest_q;
        dv_d     = last_q;
        open_d   = open_q & ~last_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      v_q      <= '0;
      h_q      <= IV;
      digest_q <= '0;
      dv_q     <= 1'b0;
      last_q   <= 1'b0;
      open_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      v_q      <= v_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
      last_q   <= last_d;
      open_q   <= open_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end

  assign digest       = digest_q;
  assign digest_valid = dv_q;
  assign busy         = state_q != IDLE;
  assign q_state      = state_q;
  assign blk_cnt      = cnt_q;
  assign err          = err_q;
endmodule

// File: tb/tb_sha1_chain_accel.sv
// tb_sha1_chain_accel: directed known-answer and randomized chain checks against a SHA-1 model
module tb_sha1_chain_accel;
  logic              clk = 1'b0;
  logic              reset_n, cfg_enable, in_valid, in_ready, in_first, in_last;
  logic [15:0][31:0] in_data;
  logic              start, err_clr;
  logic [4:0][31:0]  digest;
  logic              digest_valid, busy;
  logic [1:0]        q_state, err;
  logic [4:0]        blk_cnt;

  int errors = 0, checks = 0, cyc = 0, dv_count = 0, acc_cyc = 0;
  logic [15:0][31:0] abc_blk, empty_blk, two_a, two_b, rnd;
  logic [4:0][31:0]  abc_d, empty_d, two_d, h_ref, iv;

  sha1_chain_accel dut (
    .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .in_valid(in_valid),
    .in_ready(in_ready), .in_first(in_first), .in_last(in_last), .in_data(in_data),
    .start(start), .err_clr(err_clr), .digest(digest), .digest_valid(digest_valid),
    .busy(busy), .q_state(q_state), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (digest_valid) dv_count <= dv_count + 1;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // textbook compression: full 80-word expansion, then 80 rounds, then feed-forward
  function automatic logic [4:0][31:0] compress(input logic [4:0][31:0] h,
                                                input logic [15:0][31:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int i = 0; i < 80; i++)
      if (i < 16) w[i] = m[i];
      else w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {h[4] + e, h[3] + d, h[2] + c, h[1] + b, h[0] + a};
  endfunction

  function automatic logic [4:0][31:0] mkd(input logic [31:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [15:0][31:0] rand_blk();
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0][31:0] d, input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_wait", n < 300, 1'b1);
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_dv(output int lat);
    lat = 0;
    while (!digest_valid && lat < 300) begin @(negedge clk); lat++; end
    chk("dv_timeout", lat < 300, 1'b1);
    @(negedge clk);
    chk("dv_pulse", digest_valid, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_dv"}, digest_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_state"}, q_state, 2'b00);
    chk({tag, "_blk"}, blk_cnt, 5'd0);
    chk({tag, "_err"}, err, 2'b00);
    chk({tag, "_digest"}, digest, 160'd0);
  endtask

  initial begin
    int lat, a1, d0;
    reset_n = 1'b0; cfg_enable = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; start = 1'b0; err_clr = 1'b0;
    iv = mkd(32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0);
    abc_blk = '0; abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
    empty_blk = '0; empty_blk[0] = 32'h80000000;
    two_a = {32'h0, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70, 32'h6c6d6e6f, 32'h6b6c6d6e,
             32'h6a6b6c6d, 32'h696a6b6c, 32'h68696a6b, 32'h6768696a, 32'h66676869,
             32'h65666768, 32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
    two_b = '0; two_b[15] = 32'h000001c0;
    abc_d   = mkd(32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d);
    empty_d = mkd(32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef, 32'h95601890, 32'hafd80709);
    two_d   = mkd(32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1, 32'hf95129e5, 32'he54670f1);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_idle", in_ready, 1'b1);
    cfg_enable = 1'b0; #1;
    chk("ready_disabled", in_ready, 1'b0);
    cfg_enable = 1'b1;
    // single-block "abc" with latency
    send(abc_blk, 1'b1, 1'b1);
    chk("abc_state", q_state, 2'b01);
    chk("abc_busy", busy, 1'b1);
    wait_dv(lat);
    chk("abc_latency", lat, 81);
    chk("abc_digest", digest, abc_d);
    chk("abc_blk", blk_cnt, 5'd1);
    // empty message
    send(empty_blk, 1'b1, 1'b1);
    wait_dv(lat);
    chk("empty_digest", digest, empty_d);
    // two-block back-to-back
    d0 = dv_count;
    send(two_a, 1'b1, 1'b0);
    a1 = acc_cyc;
    send(two_b, 1'b0, 1'b1);
    chk("two_accept_gap", acc_cyc - a1, 82);
    chk("two_no_early_dv", dv_count - d0, 0);
    wait_dv(lat);
    chk("two_digest", digest, two_d);
    chk("two_blk", blk_cnt, 5'd2);
    chk("two_dv_count", dv_count - d0, 1);
    // chain block with no open message after reset
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    send(abc_blk, 1'b0, 1'b1);
    chk("orphan_err", err, 2'b01);
    wait_dv(lat);
    chk("orphan_digest", digest, abc_d);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("err_clr", err, 2'b00);
    // reset at round 40
    send(abc_blk, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    send(abc_blk, 1'b1, 1'b1);
    wait_dv(lat);
    chk("post_rst_digest", digest, abc_d);
    // new first abandons an open message
    send(rand_blk(), 1'b1, 1'b0);
    send(abc_blk, 1'b1, 1'b1);
    wait_dv(lat);
    chk("abandon_digest", digest, abc_d);
    chk("abandon_err", err, 2'b00);
    chk("abandon_blk", blk_cnt, 5'd1);
    // random single-block messages against the model
    for (int r = 0; r < 3; r++) begin
      rnd = rand_blk();
      send(rnd, 1'b1, 1'b1);
      wait_dv(lat);
      chk("rand_single", digest, compress(iv, rnd));
    end
    // 17-block random chain: the 17th overflows the block counter
    h_ref = iv;
    for (int i = 0; i < 17; i++) begin
      rnd = rand_blk();
      send(rnd, i == 0, i == 16);
      h_ref = compress(h_ref, rnd);
      if (i == 15) chk("chain_no_ovf", err, 2'b00);
      if (i == 16) chk("chain_ovf", err, 2'b10);
    end
    wait_dv(lat);
    chk("chain_digest", digest, h_ref);
    chk("chain_blk_sat", blk_cnt, 5'd16);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    // enable dropped mid-block still completes
    send(abc_blk, 1'b1, 1'b1);
    cfg_enable = 1'b0;
    wait_dv(lat);
    chk("disable_digest", digest, abc_d);
    chk("disable_ready", in_ready, 1'b0);
    chk("disable_idle", q_state, 2'b00);
    cfg_enable = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha1_chain_accel.md
# sha1_chain_accel

Parametrised SHA-1 compression accelerator with multi-block message chaining. It accepts pre-padded 512-bit blocks over a valid/ready handshake and runs one round per clock for 80 rounds. The hash state is carried across blocks of a message, and the final digest is presented on the last block. It sits behind the SHA-1 register front end as the replacement for the single-block start/latch controller.

## Interface
Parameters:
- MAX_BLOCKS, 16: maximum blocks per message; sets `blk_cnt` width.
- SYNC_STAGES, 2 (≥2): flops in the `start` synchroniser; used only with the macro.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- cfg_enable  in  1  accelerator enable; gates `in_ready`
- in_valid  in  1  block offered
- in_ready  out  1  block accepted on `in_valid & in_ready`
- in_first  in  1  block starts a new message (use IV)
- in_last  in  1  block ends the message (publish digest)
- in_data  in  32 x [15:0]  block words; `in_data[0]` = W0 (first big-endian word)
- start  in  1  asynchronous level start; used only with the macro
- err_clr  in  1  clears `err`
- digest  out  32 x [4:0]  `digest[0]` = H0
- digest_valid  out  1  one-cycle pulse
- busy  out  1  state != IDLE
- q_state  out  2  current state encoding
- blk_cnt  out  $clog2(MAX_BLOCKS+1)  blocks completed in the current message
- err  out  2  sticky: [0] chain block with no open message; [1] block-count overflow

## Operation
- States: IDLE=2'b00, ROUND=2'b01, DONE=2'b10. Code 2'b11 returns to IDLE on the next edge.
- IDLE
  - `in_ready = cfg_enable`.
  - On accept:
    - A..E <= (first ? IV : H).
    - The W buffer loads `in_data`.
    - t <= 0; state <= ROUND.
    - `in_first` and `in_last` are latched.
- ROUND
  - Each edge performs round t with the standard f/K per 20-round group: Ch/0x5A827999, Parity/0x6ED9EBA1, Maj/0x8F1BBCDC, Parity/0xCA62C1D6.
  - All additions are mod 2^32.
  - At t=79: state <= DONE.
- DONE
  - H_i <= H_i + {A..E}_i, mod 2^32.
  - `blk_cnt` increments.
  - If the latched last flag is set: digest <= new H and `digest_valid` pulses.
  - Then state <= IDLE.
- Message schedule
  - For t<16: W_t is the loaded word.
  - Otherwise: W_t = ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), held in a 16-entry circular buffer.
- Message tracking
  - A message is open from an accepted first block until the DONE of a last block.
  - `in_first` while a message is open abandons that message and restarts from IV with no error.
  - `in_first=0` with no message open:
    - Set err[0].
    - Treat the block as first (IV, `blk_cnt` restarts).
  - Non-first block accepted when `blk_cnt == MAX_BLOCKS`:
    - Set err[1].
    - Process the block; `blk_cnt` saturates.
  - `in_first & in_last` is a single-block message.
  - `err_clr` clears `err`. A same-cycle error set wins over `err_clr`.
- `cfg_enable` dropped mid-block: the current block completes; no further accepts.

## Timing
- Reset values:
  - `in_ready`, `digest_valid`, `busy`, `err`, `blk_cnt`: 0.
  - `digest`: all 0.
  - `q_state`: IDLE.
  - H: IV. No message open.
- Reset mid-operation aborts the block and discards message context. No digest is produced.
- Cycle counts, with accept on edge E0:
  - Rounds 0..79 run on E1..E80.
  - DONE update happens on E81; `digest_valid` is high in the cycle after E81.
- Latency is 81 cycles. The next accept is possible at E82, giving 82 cycles per block.
- `digest` holds until the next last-block DONE. `in_ready` is combinational from state and `cfg_enable`.

## Configuration
- SHA1_ASYNC_START_EN defined:
  - `start` passes through the SYNC_STAGES-flop synchroniser.
  - A synchronised rising edge seen in IDLE with `cfg_enable=1` acts as an accept with first=1, last=1.
  - If that edge coincides with `in_valid`, the handshake takes priority and the edge is dropped.
- Not defined: `start` is ignored, no synchroniser flops exist, and SYNC_STAGES is unused.

## Structure
- Package sha1_accel_pkg holds:
  - State enum.
  - IV constants: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - Four K constants.
  - ROUNDS=80.
  - `rotl` function.
- Sub-module sha1_msg_schedule: 16-word circular buffer with load, advance and W_t output.

## Test plan
- Single block "abc" (padded), first=last=1 -> `digest` = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; `digest_valid` high exactly 81 cycles after accept.
- Empty-message padded block -> `digest` = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", back-to-back -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - No `digest_valid` after block 1.
  - `blk_cnt`=2.
  - Second accept at E82.
- After reset, first=0 "abc" block -> err[0]=1 and the "abc" digest is still produced. `err_clr` -> err=0.
- Reset asserted at round 40 -> all outputs at reset values. A following "abc" block is correct.
- With SHA1_ASYNC_START_EN and SYNC_STAGES=2: a `start` pulse with "abc" on `in_data` -> correct digest. With `start` held high, only one block is processed.
